// File: rtl/hacd_axi4_burst_master.sv
// hacd_axi4_burst_master
//   AXI4 INCR burst initiator for the HACD memory-controller path. Accepts one
//   read or write command at a time and drives it onto the MC AXI channels.
//   Write data streams in and read data streams out beat by beat. Completion
//   is reported with a one-cycle done pulse that carries an error flag.
// Ports
//   i_clk / i_rst_n            : clock, asynchronous active-low reset
//   i_cmd_* / o_cmd_ready      : command handshake (write flag, byte addr, len-1)
//   i_wr_data* / o_wr_data_ready : write-data stream into the W channel
//   o_rd_data* / i_rd_data_ready : read-data stream out of the R channel
//   o_done_valid / o_done_err  : completion pulse and status
//   o_axi_aw* / o_axi_w* / *_axi_b* / o_axi_ar* / *_axi_r* : AXI4 master side
module hacd_axi4_burst_master #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 64,
  parameter bit WAIT_BRESP = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  input  logic                    i_cmd_write,
  input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
  input  logic [7:0]              i_cmd_len,
  input  logic [DATA_WIDTH-1:0]   i_wr_data,
  input  logic                    i_wr_data_valid,
  output logic                    o_wr_data_ready,
  output logic [DATA_WIDTH-1:0]   o_rd_data,
  output logic                    o_rd_data_valid,
  input  logic                    i_rd_data_ready,
  output logic                    o_rd_data_last,
  output logic                    o_done_valid,
  output logic                    o_done_err,
  output logic                    o_axi_awvalid,
  input  logic                    i_axi_awready,
  output logic [ADDR_WIDTH-1:0]   o_axi_awaddr,
  output logic [7:0]              o_axi_awlen,
  output logic [2:0]              o_axi_awsize,
  output logic [1:0]              o_axi_awburst,
  output logic                    o_axi_wvalid,
  input  logic                    i_axi_wready,
  output logic [DATA_WIDTH-1:0]   o_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] o_axi_wstrb,
  output logic                    o_axi_wlast,
  input  logic                    i_axi_bvalid,
  output logic                    o_axi_bready,
  input  logic [1:0]              i_axi_bresp,
  output logic                    o_axi_arvalid,
  input  logic                    i_axi_arready,
  output logic [ADDR_WIDTH-1:0]   o_axi_araddr,
  output logic [7:0]              o_axi_arlen,
  output logic [2:0]              o_axi_arsize,
  output logic [1:0]              o_axi_arburst,
  input  logic                    i_axi_rvalid,
  output logic                    o_axi_rready,
  input  logic [DATA_WIDTH-1:0]   i_axi_rdata,
  input  logic [1:0]              i_axi_rresp,
  input  logic                    i_axi_rlast
);
  localparam int SZ = $clog2(DATA_WIDTH/8);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-SZ){1'b1}}, {SZ{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_WR_ADDR, S_WR_DATA, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_DONE
  } state_t;

  state_t                  r_state;
  logic                    r_cmd_ready, r_awvalid, r_arvalid, r_bready;
  logic                    r_done_valid, r_done_err, r_err;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [7:0]              r_len, r_cnt;
  logic [2:0]              r_size;
  logic [1:0]              r_burst;

  logic w_cmd_hs, w_in_wr, w_in_rd, w_w_hs, w_r_hs, w_last, w_rd_err;

  assign w_cmd_hs = i_cmd_valid & r_cmd_ready;
  assign w_in_wr  = (r_state == S_WR_DATA);
  assign w_in_rd  = (r_state == S_RD_DATA);
  assign w_last   = (r_cnt == r_len);
  assign w_w_hs   = w_in_wr & i_wr_data_valid & i_axi_wready;
  assign w_r_hs   = w_in_rd & i_axi_rvalid & i_rd_data_ready;
  // rlast must land exactly on the final counted beat; either direction of
  // disagreement is a length mismatch.
  assign w_rd_err = r_err | (i_axi_rresp != 2'b00) | (i_axi_rlast != w_last);

  // Data channels are pass-through, gated by state so nothing leaks outside
  // the data phase (and everything reads 0 in reset).
  assign o_axi_wvalid    = w_in_wr & i_wr_data_valid;
  assign o_wr_data_ready = w_in_wr & i_axi_wready;
  assign o_axi_wdata     = w_in_wr ? i_wr_data : '0;
  assign o_axi_wstrb     = {(DATA_WIDTH/8){w_in_wr}};
  assign o_axi_wlast     = w_in_wr & w_last;
  assign o_axi_rready    = w_in_rd & i_rd_data_ready;
  assign o_rd_data_valid = w_in_rd & i_axi_rvalid;
  assign o_rd_data       = w_in_rd ? i_axi_rdata : '0;
  assign o_rd_data_last  = w_in_rd & w_last;

  assign o_cmd_ready   = r_cmd_ready;
  assign o_axi_awvalid = r_awvalid;
  assign o_axi_arvalid = r_arvalid;
  assign o_axi_bready  = r_bready;
  assign o_done_valid  = r_done_valid;
  assign o_done_err    = r_done_err;
  assign o_axi_awaddr  = r_addr;
  assign o_axi_araddr  = r_addr;
  assign o_axi_awlen   = r_len;
  assign o_axi_arlen   = r_len;
  assign o_axi_awsize  = r_size;
  assign o_axi_arsize  = r_size;
  assign o_axi_awburst = r_burst;
  assign o_axi_arburst = r_burst;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_cmd_ready  <= 1'b0;
      r_awvalid    <= 1'b0;
      r_arvalid    <= 1'b0;
      r_bready     <= 1'b0;
      r_done_valid <= 1'b0;
      r_done_err   <= 1'b0;
      r_err        <= 1'b0;
      r_addr       <= '0;
      r_len        <= '0;
      r_cnt        <= '0;
      r_size       <= '0;
      r_burst      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          // Without B tracking the response channel is simply drained.
          r_bready    <= !WAIT_BRESP;
          if (w_cmd_hs) begin
            r_cmd_ready <= 1'b0;
            r_addr      <= i_cmd_addr & ALIGN_MASK;
            r_len       <= i_cmd_len;
            r_cnt       <= '0;
            r_size      <= 3'(SZ);
            r_burst     <= 2'b01;
            if (i_cmd_write) begin
              r_awvalid <= 1'b1;
              r_state   <= S_WR_ADDR;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= S_RD_ADDR;
            end
          end
        end
        S_WR_ADDR: if (i_axi_awready) begin
          r_awvalid <= 1'b0;
          r_state   <= S_WR_DATA;
        end
        S_WR_DATA: if (w_w_hs) begin
          r_cnt <= r_cnt + 8'd1;
          if (w_last) begin
            if (WAIT_BRESP) begin
              r_bready <= 1'b1;
              r_state  <= S_WR_RESP;
            end else begin
              r_done_valid <= 1'b1;
              r_done_err   <= 1'b0;
              r_state      <= S_DONE;
            end
          end
        end
        S_WR_RESP: if (i_axi_bvalid) begin
          r_bready     <= 1'b0;
          r_done_valid <= 1'b1;
          r_done_err   <= r_err | (i_axi_bresp != 2'b00);
          r_state      <= S_DONE;
        end
        S_RD_ADDR: if (i_axi_arready) begin
          r_arvalid <= 1'b0;
          r_state   <= S_RD_DATA;
        end
        S_RD_DATA: if (w_r_hs) begin
          r_cnt <= r_cnt + 8'd1;
          // Exit on the beat count alone; rlast only feeds the error flag.
          if (w_last) begin
            r_done_valid <= 1'b1;
            r_done_err   <= w_rd_err;
            r_state      <= S_DONE;
          end else begin
            r_err <= w_rd_err;
          end
        end
        S_DONE: begin
          r_done_valid <= 1'b0;
          r_done_err   <= 1'b0;
          r_err        <= 1'b0;
          r_cmd_ready  <= 1'b1;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/hacd_axi4_burst_master.md
# hacd_axi4_burst_master

AXI4 burst initiator for the HACD memory-controller path. It accepts single read or write commands from Hawk-side logic and drives them onto the MC AXI write and read channels as INCR bursts, one transaction in flight at a time. Write data is streamed in and read data is streamed out beat by beat. Completion status is reported on a one-cycle done pulse. It is the initiator counterpart of the MC-side AXI memory responder and connects to the same AXI write and read buses.

## Interface
- DATA_WIDTH, 256: AXI data width in bits; one beat covers DATA_WIDTH/8 bytes (32 B at default).
- ADDR_WIDTH, 64: AXI address width.
- WAIT_BRESP, 1: 1 = a write completes on the B handshake; 0 = a write completes on the final W handshake, and bready is held 1.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk in 1: clock.
- rst_n in 1: asynchronous active-low reset.
- cmd_valid/cmd_ready in/out 1: command handshake.
- cmd_write in 1: 1 = write, 0 = read.
- cmd_addr in ADDR_WIDTH: byte address.
- cmd_len in 8: number of beats minus 1.
- wr_data/wr_data_valid/wr_data_ready in/in/out DATA_WIDTH/1/1: write-data stream.
- rd_data/rd_data_valid/rd_data_ready/rd_data_last out/out/in/out DATA_WIDTH/1/1/1: read-data stream.
- done_valid out 1: one-cycle completion pulse.
- done_err out 1: error status; valid only while done_valid=1.
- AXI write address: axi_awvalid/awready/awaddr/awlen/awsize/awburst: out/in/ADDR_WIDTH/8/3/2.
- AXI write data: axi_wvalid/wready/wdata/wstrb/wlast: out/in/DATA_WIDTH/DATA_WIDTH/8/1.
- AXI write response: axi_bvalid/bready/bresp: in/out/2.
- AXI read address: axi_arvalid/arready/araddr/arlen/arsize/arburst: out/in/ADDR_WIDTH/8/3/2.
- AXI read data: axi_rvalid/rready/rdata/rresp/rlast: in/out/DATA_WIDTH/2/1.

## Operation
- FSM states: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE:
  - cmd_ready=1.
  - On a cmd handshake, latch the command and go to WR_ADDR or RD_ADDR.
  - The low log2(DATA_WIDTH/8) address bits are forced to 0.
  - The beat counter is cleared.
- Address fields on AW and AR:
  - awlen/arlen = cmd_len.
  - awsize/arsize = log2(DATA_WIDTH/8), which is 5 at the default width.
  - awburst/arburst = 2'b01 (INCR).
- WR_ADDR:
  - axi_awvalid=1 until axi_awready.
  - axi_wvalid must never be asserted before the AW handshake has completed.
- WR_DATA:
  - axi_wvalid = wr_data_valid and wr_data_ready = axi_wready (combinational pass-through).
  - axi_wdata = wr_data.
  - axi_wstrb = all ones.
  - axi_wlast = 1 when the beat counter equals the latched len.
  - On the last W handshake: go to WR_RESP if WAIT_BRESP=1, else to DONE with err=0.
- WR_RESP:
  - axi_bready=1.
  - On axi_bvalid: err = (bresp != 0); go to DONE.
- RD_ADDR: axi_arvalid=1 until axi_arready.
- RD_DATA:
  - axi_rready = rd_data_ready and rd_data_valid = axi_rvalid (pass-through).
  - rd_data = axi_rdata.
  - rd_data_last = 1 on the beat whose count equals len.
  - err accumulates on any rresp != 0.
  - err is also set on a length mismatch: rlast=1 before the final beat, or rlast=0 on the final beat.
  - Exit to DONE on the beat-count match, regardless of rlast.
- DONE:
  - done_valid=1 and done_err=err for exactly one cycle.
  - Then go to IDLE; err is cleared.
- Beat counter is 8 bits and counts handshakes only; cmd_len=255 yields 256 beats with no wrap before exit.

## Timing
- Reset values: all *valid, cmd_ready, axi_bready, axi_rready, done_* = 0; all address, len and data outputs = 0; state = IDLE.
- cmd_ready rises the first cycle after reset release.
- Command accepted at edge T:
  - axi_awvalid or axi_arvalid = 1 from T+1.
  - cmd_ready = 0 from T+1 until the return to IDLE.
- AW/AR handshake at edge A: the FSM is in WR_DATA or RD_DATA from A+1. Write data therefore starts no earlier than A+1.
- Valid stability: axi_awvalid/arvalid, once high, stay high with constant address until the handshake.
- Back-to-back throughput:
  - Zero-stall write of N beats: last W handshake at A+N.
  - WAIT_BRESP=0: done_valid at A+N+1.
  - WAIT_BRESP=1: done_valid one cycle after the B handshake.
- Command turnaround: cmd_ready returns the cycle after done_valid, so the minimum command-to-command spacing is one idle cycle.
- Stalls: W and R stalls (wr_data_valid=0, wready=0, rready=0, rvalid=0) hold the state and the beat counter.
- Reset mid-burst: asynchronous return to the reset values above. No completion is reported.

## Test plan
- **Single write.** Write, addr 0x1000, len 3, zero-stall slave.
  - AW: awaddr=0x1000, awlen=3, awsize=5, awburst=1.
  - 4 W beats, wlast only on beat 4, wstrb all ones.
  - B OKAY → done_valid one cycle later with done_err=0.
- **Unaligned read.** Read, addr 0x2013, len 0.
  - araddr=0x2000.
  - One R beat with rlast=1 → rd_data_last=1, done_err=0.
- **Backpressure.**
  - Random wready/wr_data_valid and rvalid/rready stalls on len 7 transfers.
  - Data order is preserved and exactly 8 beats are transferred.
  - No axi_wvalid before the AW handshake.
- **Errors.**
  - Read with rresp=2 on beat 2 → done_err=1.
  - Read len 3 with rlast asserted on beat 2 → done_err=1 and the FSM still consumes 4 beats.
  - Write with bresp=3 → done_err=1.
- **WAIT_BRESP=0.** Write len 1 with the slave never asserting bvalid → done_valid one cycle after the last W handshake; axi_bready=1.
- **Reset mid-burst.**
  - Deassert rst_n during beat 3 of a len 7 write → all outputs 0 immediately.
  - After release: cmd_ready=1, and a new read len 0 completes normally.
